usb_rx_line_decoder: RTL and testbench
======================================

Name: usb_rx_line_decoder

Overview:
Full-speed USB receive line front end between the dplus_in/dminus_in pads and the usb_rx packet engine.
- Synchronises both lines and recovers bit timing from line transitions.
- Performs NRZI decode and bit unstuffing.
- Emits one strobed data bit per USB bit time, plus end-of-packet and line-error events.
- usb_rx consumes these signals instead of raw line samples.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time (minimum 4).
SAMPLE_POINT, 3, bit-timer count at which the line is sampled (0 .. CLKS_PER_BIT-1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
dplus_in  input  1  raw D+ line, asynchronous to clk
dminus_in  input  1  raw D- line, asynchronous to clk
rx_bit_strobe  output  1  one-cycle pulse; rx_bit is valid this cycle
rx_bit  output  1  decoded, unstuffed data bit
eop  output  1  one-cycle pulse when end-of-packet completes
rx_error  output  1  one-cycle pulse on bit-stuff violation or SE1
line_active  output  1  high from start-of-packet edge until eop or error recovery

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset state: state IDLE; synchroniser flops at J (D+=1, D-=0); prev_level=1; ones_count=0; bit timer=0.
- Reset outputs: rx_bit_strobe=0, rx_bit=0, eop=0, rx_error=0, line_active=0.
- rst asserted mid-packet aborts immediately; no eop or rx_error is generated.

Synchroniser and bit timer:
- Two flops per line. Line state from synced values: J=10, K=01, SE0=00, SE1=11.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps.
- Any change of synced D+ clears the timer to 0 that cycle (resync); this overrides the increment.
- Sample event occurs when timer==SAMPLE_POINT.

State machine:
- IDLE: line_active=0. A synced J->K transition moves to ACTIVE; timer is cleared, prev_level=1, ones_count=0.
- ACTIVE, at each sample:
  - SE0 -> EOP_WAIT; no strobe.
  - SE1 -> rx_error pulse, go to ERR_WAIT.
  - Otherwise, NRZI decode: d = (sample D+ == prev_level) ? 1 : 0; then prev_level <= sample D+.
  - Unstuffing:
    - If ones_count==6 and d==0: stuffed bit, dropped (no strobe), ones_count=0.
    - If ones_count==6 and d==1: rx_error pulse, go to ERR_WAIT.
    - Else: strobe d. ones_count = d ? ones_count+1 : 0, saturating at 6.
- EOP_WAIT, at each sample:
  - J -> eop pulse, go to IDLE.
  - SE0 -> stay (any length is accepted).
  - K or SE1 -> rx_error pulse, go to ERR_WAIT.
- ERR_WAIT: line_active stays 1. Go to IDLE on the first sample that sees J, following at least one SE0 sample; no eop is emitted.

Timing and output rules:
- Output timing: rx_bit_strobe, rx_bit, eop and rx_error are registered and assert the cycle after the sample cycle.
- Latency from pin to strobe: 2 synchroniser cycles + SAMPLE_POINT + 1.
- line_active rises the cycle after the J->K edge is detected in the synced domain. It falls in the same cycle as the eop pulse, or on ERR_WAIT exit.
- rx_bit holds its last value between strobes. At most one of rx_bit_strobe, eop, rx_error is high in any cycle.
- No back-pressure: the consumer must accept every strobe.

Optional Feature:
USB_RX_GLITCH_FILTER_EN:
- Defined: a 3-sample majority filter is added per line after the synchroniser. It adds 1 cycle of latency, and a single-cycle pulse on either line never causes a resync or a state change.
- Undefined: no filter; synced values are used directly.

Decomposition:
- Package usb_rx_line_pkg holds:
  - line_state_t enum {LS_J, LS_K, LS_SE0, LS_SE1};
  - rx_line_state_t enum {IDLE, ACTIVE, EOP_WAIT, ERR_WAIT};
  - localparam STUFF_LIMIT=6;
  - localparam LINE_IDLE=2'b10.
- One sub-module, usb_rx_bit_timer: counter with clear-on-resync and sample-pulse output, parameterised by CLKS_PER_BIT and SAMPLE_POINT.

Test Plan:
- Reset with lines idle J for 100 cycles -> all outputs 0, line_active=0, no strobes.
- SYNC pattern KJKJKJKK, 8 clocks/bit -> 8 strobes with rx_bit = 0,0,0,0,0,0,0,1; line_active high; first strobe at edge+2+3+1 cycles.
- Data byte 0xFF sent as 6 ones, a stuffed 0, then 2 ones -> exactly 8 strobes, all rx_bit=1; no rx_error.
- Seven consecutive ones with no stuffed bit -> 6 strobes, then an rx_error pulse. line_active stays 1 until SE0 then J, and no eop is produced.
- End of packet: SE0 for 2 bits then J -> single eop pulse one cycle after the J sample; line_active falls the same cycle; state IDLE.
- Mid-packet rst pulse, plus a bit period stretched to 9 clocks -> reset clears everything with no eop; without the reset, the stretched bit resyncs the timer and the bit is decoded correctly. With USB_RX_GLITCH_FILTER_EN defined, a 1-cycle D+ glitch causes no extra strobe.

Source files
------------

// File: rtl/usb_rx_line_decoder_pkg.sv
// Shared line-state and receiver FSM types for the full-speed USB receive line decoder.
// Line encodings are {D+, D-} as seen after synchronisation.
package usb_rx_line_pkg;

    typedef enum logic [1:0] {
        LS_J   = 2'b10,
        LS_K   = 2'b01,
        LS_SE0 = 2'b00,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACTIVE   = 2'b01,
        EOP_WAIT = 2'b10,
        ERR_WAIT = 2'b11
    } rx_line_state_t;

    localparam int         STUFF_LIMIT = 6;
    localparam logic [1:0] LINE_IDLE   = 2'b10;

    function automatic line_state_t decode_line(input logic [1:0] lines);
        return line_state_t'(lines);
    endfunction

endpackage

// File: rtl/usb_rx_line_decoder_if.sv
// Pad-side inputs and decoded bit/event outputs of the USB receive line decoder.
// master = decoder side, slave = pad driver / packet engine side.
interface usb_rx_line_if;
    logic dplus_in;
    logic dminus_in;
    logic rx_bit_strobe;
    logic rx_bit;
    logic eop;
    logic rx_error;
    logic line_active;

    modport master (
        input  dplus_in,
        input  dminus_in,
        output rx_bit_strobe,
        output rx_bit,
        output eop,
        output rx_error,
        output line_active
    );

    modport slave (
        output dplus_in,
        output dminus_in,
        input  rx_bit_strobe,
        input  rx_bit,
        input  eop,
        input  rx_error,
        input  line_active
    );
endinterface

// File: rtl/usb_rx_line_decoder_bit_timer.sv
// Bit-time counter: wraps every CLKS_PER_BIT clocks, restarts on a line edge,
// and flags the cycle in which the line should be sampled.
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sample
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_POINT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_now;

    // A resync makes the current cycle count as zero, so the edge cycle itself is bit-time 0.
    always_comb begin
        count_now = clear ? '0 : count_q;
    end

    assign sample = (count_now == SAMPLE_AT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (count_now == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_now + CW'(1);
        end
    end
endmodule

// File: rtl/usb_rx_line_decoder.sv
// Full-speed USB receive front end: synchronise, recover bit timing, NRZI decode, unstuff, flag EOP/errors.
// Define USB_RX_GLITCH_FILTER_EN to add a 3-sample majority filter per line after the synchroniser.
module usb_rx_line_decoder
    import usb_rx_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic          clk,
    input  logic          rst,
    usb_rx_line_if.master line
);
    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LIMIT);

    logic [1:0]     meta_q;
    logic [1:0]     sync_q;
    logic [1:0]     line_bits;
    logic [1:0]     last_bits_q;
    line_state_t    line_now;
    line_state_t    line_last;
    logic           resync;
    logic           jk_edge;
    logic           sample;

    rx_line_state_t state_q;
    rx_line_state_t state_d;
    logic           prev_level_q;
    logic           prev_level_d;
    logic [2:0]     ones_q;
    logic [2:0]     ones_d;
    logic           seen_se0_q;
    logic           seen_se0_d;
    logic           strobe_q;
    logic           strobe_d;
    logic           bit_q;
    logic           bit_d;
    logic           eop_q;
    logic           eop_d;
    logic           err_q;
    logic           err_d;
    logic           d_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= {line.dplus_in, line.dminus_in};
            sync_q <= meta_q;
        end
    end

`ifdef USB_RX_GLITCH_FILTER_EN
    logic [1:0] hist1_q;
    logic [1:0] hist2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist1_q <= LINE_IDLE;
            hist2_q <= LINE_IDLE;
        end else begin
            hist1_q <= sync_q;
            hist2_q <= hist1_q;
        end
    end

    // Bitwise majority: a value must persist for two samples before it is believed.
    assign line_bits = (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign line_bits = sync_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            last_bits_q <= LINE_IDLE;
        end else begin
            last_bits_q <= line_bits;
        end
    end

    assign line_now  = decode_line(line_bits);
    assign line_last = decode_line(last_bits_q);
    assign resync    = line_bits[1] ^ last_bits_q[1];
    assign jk_edge   = (line_last == LS_J) && (line_now == LS_K);

    usb_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (resync),
        .sample (sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_level_q <= 1'b1;
            ones_q       <= '0;
            seen_se0_q   <= 1'b0;
            strobe_q     <= 1'b0;
            bit_q        <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            ones_q       <= ones_d;
            seen_se0_q   <= seen_se0_d;
            strobe_q     <= strobe_d;
            bit_q        <= bit_d;
            eop_q        <= eop_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_level_d = prev_level_q;
        ones_d       = ones_q;
        seen_se0_d   = seen_se0_q;
        strobe_d     = 1'b0;
        bit_d        = bit_q;
        eop_d        = 1'b0;
        err_d        = 1'b0;
        d_bit        = 1'b0;
        case (state_q)
            IDLE: begin
                if (jk_edge) begin
                    state_d      = ACTIVE;
                    prev_level_d = 1'b1;
                    ones_d       = '0;
                    // With SAMPLE_POINT 0 the first K is sampled in the same cycle its edge appears.
                    if (sample) begin
                        strobe_d     = 1'b1;
                        bit_d        = 1'b0;
                        prev_level_d = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                if (sample) begin
                    case (line_now)
                        LS_SE0: begin
                            state_d = EOP_WAIT;
                        end
                        LS_SE1: begin
                            err_d      = 1'b1;
                            state_d    = ERR_WAIT;
                            seen_se0_d = 1'b0;
                        end
                        default: begin
                            d_bit        = (line_bits[1] == prev_level_q);
                            prev_level_d = line_bits[1];
                            if (ones_q == STUFF_MAX) begin
                                if (d_bit) begin
                                    err_d      = 1'b1;
                                    state_d    = ERR_WAIT;
                                    seen_se0_d = 1'b0;
                                end else begin
                                    ones_d = '0;
                                end
                            end else begin
                                strobe_d = 1'b1;
                                bit_d    = d_bit;
                                ones_d   = d_bit ? ones_q + 3'd1 : 3'd0;
                            end
                        end
                    endcase
                end
            end
            EOP_WAIT: begin
                if (sample) begin
                    case (line_now)
                        LS_J: begin
                            eop_d   = 1'b1;
                            state_d = IDLE;
                        end
                        LS_SE0: begin
                            state_d = EOP_WAIT;
                        end
                        default: begin
                            err_d      = 1'b1;
                            state_d    = ERR_WAIT;
                            seen_se0_d = 1'b0;
                        end
                    endcase
                end
            end
            ERR_WAIT: begin
                if (sample) begin
                    if (line_now == LS_SE0) begin
                        seen_se0_d = 1'b1;
                    end else if ((line_now == LS_J) && seen_se0_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign line.rx_bit_strobe = strobe_q;
    assign line.rx_bit        = bit_q;
    assign line.eop           = eop_q;
    assign line.rx_error      = err_q;
    assign line.line_active   = (state_q != IDLE);

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Bench for usb_rx_line_decoder: packets are built from data bits (stuff + NRZI encode) and the
// decoded strobes/events are compared with the original bits and the expected event timing.
module tb_usb_rx_line_decoder;
    localparam int CPB = 8;
    localparam int SP  = 3;
`ifdef USB_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif
    localparam int         LAT     = 2 + SP + 1 + FILT;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    usb_rx_line_if bus();

    usb_rx_line_decoder #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .line (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: only this process writes these; the stimulus works on deltas.
    bit   got_q[$];
    int   strobe_cyc_q[$];
    int   eop_cnt   = 0;
    int   err_cnt   = 0;
    int   eop_cyc   = -1;
    int   fall_cyc  = -1;
    int   multi_cnt = 0;
    int   la_cnt    = 0;
    logic la_prev   = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_bit_strobe === 1'b1) begin
            got_q.push_back(bus.rx_bit);
            strobe_cyc_q.push_back(cyc);
        end
        if (bus.eop === 1'b1) begin
            eop_cnt++;
            eop_cyc = cyc;
        end
        if (bus.rx_error === 1'b1) err_cnt++;
        if (int'(bus.rx_bit_strobe) + int'(bus.eop) + int'(bus.rx_error) > 1) multi_cnt++;
        if (bus.line_active === 1'b1) la_cnt++;
        if (la_prev && (bus.line_active !== 1'b1)) fall_cyc = cyc;
        la_prev = bus.line_active;
    end

    int         checks  = 0;
    int         errors  = 0;
    bit         data_q[$];
    bit         exp_q[$];
    logic [1:0] sym_q[$];
    int         len_q[$];
    int         eop_idx    = 0;
    int         glitch_idx = -1;
    int         edge_cyc   = 0;

    task automatic applyStimulus(input logic [1:0] sym, input int clocks);
        bus.dplus_in  = sym[1];
        bus.dminus_in = sym[0];
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Model: SYNC + data bits, bit-stuffed over the whole stream, NRZI from idle J, then SE0 SE0 J + idle.
    task automatic buildPacket(input bit stuff, input bit stretch);
        bit   stream[$];
        logic level;
        int   ones;
        exp_q.delete();
        sym_q.delete();
        len_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(i == 7);
        foreach (data_q[i]) exp_q.push_back(data_q[i]);
        ones = 0;
        foreach (exp_q[i]) begin
            stream.push_back(exp_q[i]);
            ones = exp_q[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                stream.push_back(1'b0);
                ones = 0;
            end
        end
        level = 1'b1;
        foreach (stream[i]) begin
            if (!stream[i]) level = ~level;
            sym_q.push_back(level ? SYM_J : SYM_K);
            len_q.push_back(CPB);
        end
        if (stretch) begin
            for (int i = 0; i + 1 < sym_q.size(); i++) begin
                if (sym_q[i][1] != sym_q[i+1][1] && $urandom_range(0, 3) == 0)
                    len_q[i] = ($urandom_range(0, 1) == 1) ? CPB + 1 : CPB - 1;
            end
        end
        eop_idx = sym_q.size();
        sym_q.push_back(SYM_SE0); len_q.push_back(CPB);
        sym_q.push_back(SYM_SE0); len_q.push_back(CPB);
        sym_q.push_back(SYM_J);   len_q.push_back(CPB);
        sym_q.push_back(SYM_J);   len_q.push_back(3 * CPB);
    endtask

    task automatic sendRange(input int lo, input int hi);
        logic [1:0] s;
        if (lo == 0) edge_cyc = cyc;
        for (int i = lo; i < hi; i++) begin
            s = sym_q[i];
            if (i == glitch_idx && len_q[i] >= 6) begin
                applyStimulus(s, 4);
                applyStimulus({~s[1], s[0]}, 1);
                applyStimulus(s, len_q[i] - 5);
            end else begin
                applyStimulus(s, len_q[i]);
            end
        end
    endtask

    task automatic runChecked(input string tag, input int split, input int n_bits,
                              input int n_eop, input int n_err);
        int          b_bits;
        int          b_eop;
        int          b_err;
        logic [63:0] got_v;
        logic [63:0] exp_v;
        b_bits = got_q.size();
        b_eop  = eop_cnt;
        b_err  = err_cnt;
        if (split > 0) begin
            sendRange(0, split);
            checkOutput({tag, " line_active mid"}, 64'(bus.line_active), 64'd1);
            sendRange(split, sym_q.size());
        end else begin
            sendRange(0, sym_q.size());
        end
        got_v = '0;
        exp_v = '0;
        for (int i = 0; i < n_bits && i < 64; i++) exp_v[i] = exp_q[i];
        for (int i = b_bits; i < got_q.size() && i - b_bits < 64; i++) got_v[i - b_bits] = got_q[i];
        checkOutput({tag, " strobe count"}, 64'(got_q.size() - b_bits), 64'(n_bits));
        checkOutput({tag, " bits"}, got_v, exp_v);
        checkOutput({tag, " eop count"}, 64'(eop_cnt - b_eop), 64'(n_eop));
        checkOutput({tag, " rx_error count"}, 64'(err_cnt - b_err), 64'(n_err));
        checkOutput({tag, " line_active after"}, 64'(bus.line_active), 64'd0);
    endtask

    initial begin
        int b_bits;
        int b_eop;
        int b_err;
        int b_la;
        int sumlen;
        int n;
        bit done;

        bus.dplus_in  = 1'b1;
        bus.dminus_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(SYM_J, 3);
        rst = 1'b0;
        applyStimulus(SYM_J, 100);
        checkOutput("reset strobes", 64'(got_q.size()), 64'd0);
        checkOutput("reset eop", 64'(eop_cnt), 64'd0);
        checkOutput("reset rx_error", 64'(err_cnt), 64'd0);
        checkOutput("reset line_active", 64'(bus.line_active), 64'd0);
        checkOutput("reset rx_bit", 64'(bus.rx_bit), 64'd0);

        $display("[TB] SYNC + 0xFF packet with stuffed bit");
        data_q = '{1, 1, 1, 1, 1, 1, 1, 1};
        buildPacket(1'b1, 1'b0);
        b_bits = got_q.size();
        b_la   = la_cnt;
        runChecked("ff", 4, 16, 1, 0);
        sumlen = 0;
        for (int i = 0; i < eop_idx + 2; i++) sumlen += len_q[i];
        checkOutput("ff first strobe cycle", 64'(strobe_cyc_q[b_bits]), 64'(edge_cyc + LAT));
        checkOutput("ff eop cycle", 64'(eop_cyc), 64'(edge_cyc + sumlen + LAT));
        checkOutput("ff line_active fall with eop", 64'(fall_cyc), 64'(eop_cyc));
        checkOutput("ff line_active cycles", 64'(la_cnt - b_la), 64'(sumlen + 3));

        $display("[TB] seven ones without stuffing");
        data_q = '{0, 1, 1, 1, 1, 1, 1, 1};
        buildPacket(1'b0, 1'b0);
        runChecked("sevenones", eop_idx + 1, 15, 0, 1);

        $display("[TB] SE1 inside packet");
        data_q = '{1, 0, 1};
        buildPacket(1'b1, 1'b0);
        sym_q[9] = SYM_SE1;
        runChecked("se1", 0, 9, 0, 1);

        $display("[TB] K during EOP");
        data_q = '{1, 1};
        buildPacket(1'b1, 1'b0);
        sym_q.insert(eop_idx + 1, SYM_K);
        len_q.insert(eop_idx + 1, CPB);
        runChecked("eopk", 0, 10, 0, 1);

        $display("[TB] stretched bit");
        data_q = '{1, 0, 1, 1, 0, 0, 1};
        buildPacket(1'b1, 1'b0);
        done = 1'b0;
        for (int i = 8; i + 1 < eop_idx; i++) begin
            if (!done && sym_q[i][1] != sym_q[i+1][1]) begin
                len_q[i] = CPB + 1;
                done = 1'b1;
            end
        end
        runChecked("stretch", 0, 15, 1, 0);

        $display("[TB] reset mid-packet");
        data_q.delete();
        for (int i = 0; i < 16; i++) data_q.push_back($urandom_range(0, 1) == 1);
        buildPacket(1'b1, 1'b0);
        b_eop = eop_cnt;
        b_err = err_cnt;
        sendRange(0, 12);
        checkOutput("midrst line_active before", 64'(bus.line_active), 64'd1);
        rst = 1'b1;
        applyStimulus(SYM_J, 1);
        rst = 1'b0;
        b_bits = got_q.size();
        applyStimulus(SYM_J, 40);
        checkOutput("midrst strobes after", 64'(got_q.size() - b_bits), 64'd0);
        checkOutput("midrst eop", 64'(eop_cnt - b_eop), 64'd0);
        checkOutput("midrst rx_error", 64'(err_cnt - b_err), 64'd0);
        checkOutput("midrst line_active", 64'(bus.line_active), 64'd0);
        checkOutput("midrst rx_bit", 64'(bus.rx_bit), 64'd0);

`ifdef USB_RX_GLITCH_FILTER_EN
        $display("[TB] idle glitch");
        b_bits = got_q.size();
        applyStimulus(SYM_SE0, 1);
        applyStimulus(SYM_J, 30);
        checkOutput("glitch idle strobes", 64'(got_q.size() - b_bits), 64'd0);
        checkOutput("glitch idle line_active", 64'(bus.line_active), 64'd0);
`endif

        $display("[TB] random packets");
        for (int p = 0; p < 12; p++) begin
            data_q.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) data_q.push_back($urandom_range(0, 3) != 0);
            buildPacket(1'b1, 1'b1);
`ifdef USB_RX_GLITCH_FILTER_EN
            glitch_idx = $urandom_range(8, eop_idx - 1);
`endif
            runChecked($sformatf("rand%0d", p), 0, exp_q.size(), 1, 0);
            glitch_idx = -1;
            applyStimulus(SYM_J, $urandom_range(4, 20));
        end

        checkOutput("exclusive strobe/eop/error", 64'(multi_cnt), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
